// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams one pass of a local memory, addressed by an external up_counter.
// Ports:
//   clk, reset (async, active-low)        clock and reset
//   start                                  request one pass (sampled in IDLE only)
//   addr / cnt_en / cnt_clr                counter value in, advance enable out, sync clear out
//   wr_en / wr_addr / wr_data              memory load port
//   m_data / m_valid / m_last / m_ready    output stream
//   m_par                                  XOR of m_data qualified by m_valid (MEM_STREAM_READER_PARITY_EN only)
//   busy / done                            busy outside IDLE; one-cycle done at the end of a pass
// Optional feature macro: MEM_STREAM_READER_PARITY_EN
module mem_stream_reader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int TERM_CNT = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              cnt_en,
  output logic              cnt_clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
`ifdef MEM_STREAM_READER_PARITY_EN
  output logic              m_par,
`endif
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] TERM = TERM_CNT[ADDR_W-1:0];
  typedef enum logic [1:0] {IDLE, CLEAR, READ, DRAIN} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data;
  logic rd_vld, rd_last, pop;
  logic [1:0] occ;
  // output buffer entries hold {last, data}; b0 is the head driving the stream
  logic [DATA_W:0] b0, b1;
  assign m_valid = occ != 2'd0;
  assign m_data  = b0[DATA_W-1:0];
  assign m_last  = m_valid & b0[DATA_W];
  assign pop     = m_valid & m_ready;
  // issue only while buffer words plus the in-flight read stay under 2; a word
  // leaving this cycle frees its slot, which sustains one word per cycle
  assign cnt_en  = state == READ && (occ == 2'd0 || (occ == 2'd1 && (!rd_vld || pop)));
`ifdef MEM_STREAM_READER_PARITY_EN
  assign m_par = m_valid & ^m_data;
`endif
  always_comb
    nxt = state == IDLE  ? (start ? CLEAR : IDLE) :
          state == CLEAR ? READ :
          state == READ  ? (cnt_en && addr == TERM ? DRAIN : READ) :
                           (pop && m_last ? IDLE : DRAIN);
  // memory is never reset; nonblocking read gives old data on a same-address write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (cnt_en) rd_data <= mem[addr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      occ     <= 2'd0;
      b0      <= '0;
      b1      <= '0;
    end else begin
      state   <= nxt;
      cnt_clr <= state == IDLE && start;
      busy    <= nxt != IDLE;
      done    <= state == DRAIN && nxt == IDLE;
      rd_vld  <= cnt_en;
      rd_last <= cnt_en && addr == TERM;
      occ     <= occ + {1'b0, rd_vld} - {1'b0, pop};
      if (rd_vld && (occ == 2'd0 || (occ == 2'd1 && pop))) b0 <= {rd_last, rd_data};
      else if (pop) b0 <= b1;
      if (rd_vld && (occ == 2'd2 || (occ == 2'd1 && !pop))) b1 <= {rd_last, rd_data};
    end
  end
endmodule
